// File: rtl/alu_pkg.sv
// Shared constants for the structural ALU: opcodes, status-register bit
// positions and the datapath width, plus a helper that packs the flags.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;

    function automatic logic [3:0] mk_sreg(input logic c, input logic z,
                                           input logic n, input logic v);
        logic [3:0] s;
        s         = '0;
        s[SREG_C] = c;
        s[SREG_Z] = z;
        s[SREG_N] = n;
        s[SREG_V] = v;
        return s;
    endfunction

endpackage

// File: rtl/alu_struct_if.sv
// Operand/opcode and result/status bundle between the datapath and the ALU.
interface alu_struct_if;
    import alu_pkg::*;

    logic [3:0]        function_select_lines;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
    logic [3:0]        SREG;

    modport master (output function_select_lines, A, B,
                    input  res_hi, res_lo, SREG);
    modport slave  (input  function_select_lines, A, B,
                    output res_hi, res_lo, SREG);
endinterface

// File: rtl/alu_addsub8.sv
// 8-bit ripple-carry adder/subtractor; subtract inverts B and forces carry-in.
module alu_addsub8
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   carry;

    assign b_eff    = b ^ {DATA_W{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    assign cout = carry[DATA_W];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf  = carry[DATA_W] ^ carry[DATA_W-1];
endmodule

// File: rtl/alu_struct.sv
// Registered 8-bit ALU (add/sub/logic, optional mul/div).
// Define ALU_MULDIV_EN to build the multiplier and divider; otherwise MUL/DIV act as NOP.
module alu_struct
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_struct_if.slave  bus
);
    logic [DATA_W-1:0] res_hi_q, res_hi_d;
    logic [DATA_W-1:0] res_lo_q, res_lo_d;
    logic [3:0]        sreg_q, sreg_d;

    logic [DATA_W-1:0] as_sum;
    logic              as_cout;
    logic              as_ovf;
    logic              as_sub;
    logic              borrow;
    logic [DATA_W-1:0] logic_res;

    assign as_sub = (bus.function_select_lines == OP_SUB) ||
                    (bus.function_select_lines == OP_CMP);
    // Carry-out of A + ~B + 1 is the inverse of the unsigned borrow.
    assign borrow = ~as_cout;

    alu_addsub8 u_addsub (
        .a    (bus.A),
        .b    (bus.B),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

`ifdef ALU_MULDIV_EN
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;

    // Array multiplier: sum of shifted AND-gated partial products.
    always_comb begin
        prod = '0;
        for (int i = 0; i < DATA_W; i++) begin
            prod = prod + ({{DATA_W{1'b0}}, bus.A & {DATA_W{bus.B[i]}}} << i);
        end
    end

    // Restoring divider: shift in one dividend bit per step, subtract when it fits.
    always_comb begin
        logic [DATA_W:0] part;
        part = '0;
        quo  = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            part = {part[DATA_W-1:0], bus.A[i]};
            if (part >= {1'b0, bus.B}) begin
                part   = part - {1'b0, bus.B};
                quo[i] = 1'b1;
            end
        end
        rem = part[DATA_W-1:0];
    end
`endif

    assign logic_res = (bus.function_select_lines == OP_AND) ? (bus.A & bus.B) :
                       (bus.function_select_lines == OP_OR)  ? (bus.A | bus.B) :
                                                               (bus.A ^ bus.B);

    always_comb begin
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        sreg_d   = sreg_q;
        case (bus.function_select_lines)
            OP_ADD: begin
                res_hi_d = '0;
                res_lo_d = as_sum;
                sreg_d   = mk_sreg(as_cout, as_sum == '0, as_sum[DATA_W-1], as_ovf);
            end
            OP_SUB: begin
                res_hi_d = '0;
                res_lo_d = as_sum;
                sreg_d   = mk_sreg(borrow, as_sum == '0, as_sum[DATA_W-1], as_ovf);
            end
            OP_CMP: begin
                sreg_d   = mk_sreg(borrow, as_sum == '0, as_sum[DATA_W-1], as_ovf);
            end
            OP_AND, OP_OR, OP_XOR: begin
                res_hi_d = '0;
                res_lo_d = logic_res;
                sreg_d   = mk_sreg(1'b0, logic_res == '0, logic_res[DATA_W-1], 1'b0);
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                res_hi_d = prod[2*DATA_W-1:DATA_W];
                res_lo_d = prod[DATA_W-1:0];
                sreg_d   = mk_sreg(prod[2*DATA_W-1:DATA_W] != '0, prod == '0,
                                   prod[2*DATA_W-1], 1'b0);
            end
            OP_DIV: begin
                if (bus.B == '0) begin
                    res_hi_d = bus.A;
                    res_lo_d = '1;
                    sreg_d   = mk_sreg(1'b0, 1'b0, 1'b1, 1'b1);
                end else begin
                    res_hi_d = rem;
                    res_lo_d = quo;
                    sreg_d   = mk_sreg(1'b0, quo == '0, quo[DATA_W-1], 1'b0);
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_hi_q <= '0;
            res_lo_q <= '0;
            sreg_q   <= '0;
        end else begin
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            sreg_q   <= sreg_d;
        end
    end

    assign bus.res_hi = res_hi_q;
    assign bus.res_lo = res_lo_q;
    assign bus.SREG   = sreg_q;
endmodule

// File: tb/tb_alu_struct.sv
// Self-checking bench for alu_struct: directed test-plan vectors plus random
// traffic against a plain-arithmetic reference model. Honours ALU_MULDIV_EN.
module clock (output logic clk);
    initial clk = 1'b0;
    always #1 clk = ~clk;
endmodule

module tb_alu_struct;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] m_hi, m_lo;
    logic [3:0] m_sreg;

    clock u_clk (.clk(clk));
    alu_struct_if bus ();
    alu_struct dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_flags(input logic c, input logic z, input logic n, input logic v);
        m_sreg = {v, n, z, c};
    endtask

    // Reference behaviour written straight from the opcode table.
    task automatic model_step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int s, sa, sb, sv, p;
        logic [7:0] r8;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd1: begin
                s = int'(a) + int'(b); sv = sa + sb;
                m_lo = s[7:0]; m_hi = 8'h00;
                set_flags(s > 255, m_lo == 0, m_lo[7], sv > 127 || sv < -128);
            end
            4'd2, 4'd5: begin
                s = int'(a) - int'(b); sv = sa - sb; r8 = s[7:0];
                if (op == 4'd2) begin m_lo = r8; m_hi = 8'h00; end
                set_flags(a < b, r8 == 0, r8[7], sv > 127 || sv < -128);
            end
`ifdef ALU_MULDIV_EN
            4'd3: begin
                p = int'(a) * int'(b);
                m_hi = p[15:8]; m_lo = p[7:0];
                set_flags(m_hi != 0, p == 0, p[15], 1'b0);
            end
            4'd4: begin
                if (b == 0) begin
                    m_lo = 8'hFF; m_hi = a;
                    set_flags(1'b0, 1'b0, 1'b1, 1'b1);
                end else begin
                    m_lo = a / b; m_hi = a % b;
                    set_flags(1'b0, m_lo == 0, m_lo[7], 1'b0);
                end
            end
`endif
            4'd6, 4'd7, 4'd8: begin
                r8 = (op == 4'd6) ? (a & b) : (op == 4'd7) ? (a | b) : (a ^ b);
                m_lo = r8; m_hi = 8'h00;
                set_flags(1'b0, r8 == 0, r8[7], 1'b0);
            end
            default: begin
            end
        endcase
    endtask

    task automatic model_reset();
        m_hi = 8'h00; m_lo = 8'h00; m_sreg = 4'h0;
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".res"}, {bus.res_hi, bus.res_lo}, {m_hi, m_lo});
        cmp({tag, ".sreg"}, {12'h0, bus.SREG}, {12'h0, m_sreg});
    endtask

    // Apply inputs on the falling edge, capture on the rising edge, check 1 later.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input string tag);
        @(negedge clk);
        bus.function_select_lines = op;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        model_step(op, a, b);
        #1;
        check_model(tag);
    endtask

    task automatic lit(input string nm, input logic [15:0] res, input logic [3:0] sreg);
        cmp({nm, ".lit_res"}, {bus.res_hi, bus.res_lo}, res);
        cmp({nm, ".lit_sreg"}, {12'h0, bus.SREG}, {12'h0, sreg});
    endtask

    function automatic logic [7:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            3: return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.function_select_lines = 4'd1;
        bus.A = 8'h11;
        bus.B = 8'h22;
        model_reset();
        @(posedge clk);
        #1;
        lit("reset", 16'h0000, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4'd1, 8'd6, 8'd9, "add");
        lit("add", 16'h000F, 4'h0);
        do_op(4'd2, 8'd3, 8'd6, "sub");
        lit("sub", 16'h00FD, 4'h5);
`ifdef ALU_MULDIV_EN
        do_op(4'd3, 8'd127, 8'd125, "mul");
        lit("mul", 16'h3E03, 4'h1);
        do_op(4'd4, 8'd1, 8'd2, "div");
        lit("div", 16'h0100, 4'h2);
        do_op(4'd0, 8'd77, 8'd3, "nop");
        lit("nop", 16'h0100, 4'h2);
        do_op(4'd5, 8'd5, 8'd5, "cmp");
        lit("cmp", 16'h0100, 4'h2);
`else
        do_op(4'd3, 8'd127, 8'd125, "mul_off");
        lit("mul_off", 16'h00FD, 4'h5);
        do_op(4'd4, 8'd0, 8'd0, "div_off");
        lit("div_off", 16'h00FD, 4'h5);
        do_op(4'd5, 8'd5, 8'd5, "cmp");
        lit("cmp", 16'h00FD, 4'h2);
`endif
        do_op(4'd6, 8'd13, 8'd85, "and");
        lit("and", 16'h0005, 4'h0);
        do_op(4'd7, 8'd13, 8'd85, "or");
        lit("or", 16'h005D, 4'h0);
        do_op(4'd8, 8'd13, 8'd85, "xor");
        lit("xor", 16'h0058, 4'h0);
`ifdef ALU_MULDIV_EN
        do_op(4'd4, 8'd13, 8'd0, "div0");
        lit("div0", 16'h0DFF, 4'hC);
`endif
        do_op(4'd12, 8'd1, 8'd1, "op12");
        do_op(4'd1, 8'h7F, 8'h01, "add_ovf");
        do_op(4'd1, 8'hFF, 8'h01, "add_carry");

        // Reset in the middle of traffic discards the pending ADD.
        @(negedge clk);
        bus.function_select_lines = 4'd1;
        bus.A = 8'h40;
        bus.B = 8'h41;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_model("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            do_op(4'($urandom_range(0, 15)), pick_val(), pick_val(), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_struct.md
# alu_struct

Registered 8-bit arithmetic/logic unit built structurally from a ripple-carry adder/subtractor, an array multiplier and a restoring divider. It takes two 8-bit operands and a 4-bit function select, and produces a 16-bit result as two bytes plus a 4-bit status register. It sits in the datapath as the single execution unit. Results and flags update on the clock edge after the operands are applied.

## Interface
Parameters: none; widths are fixed by the opcode set.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- res_hi  out  8  upper result byte (product high byte / division remainder).
- res_lo  out  8  lower result byte (primary result / quotient).
- SREG  out  4  status flags, registered:
  - bit0 C (carry/borrow)
  - bit1 Z (zero)
  - bit2 N (negative)
  - bit3 V (overflow / divide error)
- function_select_lines  in  4  opcode.
- A  in  8  operand A.
- B  in  8  operand B.

## Operation
- Opcodes (applied to A, B; results are written unless stated otherwise):
  - 0 NOP: hold res and SREG.
  - 1 ADD: res_lo = A+B, res_hi = 0. C = carry out; V = signed overflow.
  - 2 SUB: res_lo = A−B, res_hi = 0. C = 1 when A<B unsigned (borrow); V = signed overflow.
  - 3 MUL: unsigned {res_hi,res_lo} = A×B. C = (res_hi≠0); V = 0.
  - 4 DIV: unsigned; res_lo = A/B, res_hi = A%B. C = 0.
    - B = 0: res_lo = 0xFF, res_hi = A, V = 1.
    - Otherwise V = 0.
  - 5 CMP: computes A−B; updates SREG exactly as SUB; res held.
  - 6 AND, 7 OR, 8 XOR: res_lo = bitwise result, res_hi = 0. C = 0, V = 0.
  - 9–15: treated as NOP.
- Z flag:
  - 16-bit ops (MUL): set when the full 16-bit result is zero.
  - DIV: set when the quotient is zero.
  - All other ops: set when res_lo is zero.
- N flag:
  - MUL: bit 15 of the result.
  - All other ops: bit 7 of res_lo.
- All arithmetic is modulo its stated width; no saturation.

## Timing
- Reset: asynchronous assertion; res_hi, res_lo and SREG all clear to 0 immediately.
- Reset release: synchronous; the first capture occurs on the first rising clk edge after rst_n deasserts.
- Latency: one cycle. Inputs sampled at rising edge N produce outputs valid after edge N.
- No handshake: every edge executes whatever opcode is present. Operands may change every cycle.
- MUL and DIV are fully combinational, so a single-cycle result is required. Clock frequency must accommodate the divider path.
- Reset asserted mid-operation discards the in-flight result.

## Configuration
- ALU_MULDIV_EN: when defined, the multiplier and divider are instantiated and opcodes 3 and 4 behave as specified.
- When undefined, neither is synthesized and opcodes 3 and 4 act as NOP (res and SREG held).

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_NOP…OP_XOR);
  - SREG bit-index constants (SREG_C, SREG_Z, SREG_N, SREG_V);
  - the width constant DATA_W = 8.
- One natural sub-module: alu_addsub8, an 8-bit ripple-carry adder with a subtract input (B inverted, carry-in 1). It outputs the sum, carry out and overflow, and is shared by ADD, SUB and CMP.
- A free-running clock generator module named clock, with a period of 2 time units, is used by benches only. It is not synthesized.

## Test plan
- Reset asserted → res = 0x0000, SREG = 0. Then ADD A=6, B=9 → res = 0x000F, SREG = 0.
- SUB A=3, B=6 → res_lo = 0xFD, res_hi = 0; C = 1, N = 1, Z = 0, V = 0.
- MUL A=127, B=125 → res_hi = 0x3E, res_lo = 0x03; C = 1, N = 0, Z = 0.
- DIV A=1, B=2 → res_lo = 0x00, res_hi = 0x01, Z = 1. Then NOP → outputs unchanged.
- CMP A=5, B=5 → SREG Z = 1, C = 0, N = 0, V = 0; res unchanged (0x0100).
- A=13, B=85, in order:
  - AND → res_lo = 0x05.
  - OR → res_lo = 0x5D.
  - XOR → res_lo = 0x58.
  - DIV with B=0 → res_lo = 0xFF, res_hi = A, V = 1.
